// File: rtl/mvm_sequencer.sv
// mvm_sequencer: loads an M x N signed matrix and an N-vector over a
// valid/ready stream, then drives an external saturating MAC one row at a
// time and returns each row's dot product over a valid/ready output stream.
module mvm_sequencer #(
   parameter int M       = 3,
   parameter int N       = 3,
   parameter int W       = 10,
   parameter int ACCW    = 20,
   parameter int MAC_LAT = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [W-1:0]    input_data,
   input  logic            input_valid,
   output logic            input_ready,
   output logic [W-1:0]    mac_a,
   output logic [W-1:0]    mac_b,
   output logic            mac_valid_in,
   output logic            mac_clr,
   input  logic [ACCW-1:0] mac_f,
   input  logic            mac_valid_out,
   output logic [ACCW-1:0] output_data,
   output logic            output_valid,
   input  logic            output_ready
);

   // Matrix words occupy slots 0..M*N-1 in row-major order, vector words follow.
   localparam int TOTAL = M * N + N;
   localparam int LW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int RW    = (M > 1) ? $clog2(M) : 1;
   localparam int SMAX  = (N > MAC_LAT) ? N : MAC_LAT;
   localparam int SW    = (SMAX > 1) ? $clog2(SMAX) : 1;

   typedef enum logic [2:0] {
      LOAD,
      CLR,
      ISSUE,
      DRAIN,
      OUT
   } state_t;

   state_t state, state_next;

   logic [W-1:0]  words [TOTAL];
   logic [LW-1:0] load_cnt;
   logic [RW-1:0] row;
   logic [SW-1:0] step;
   logic [LW-1:0] a_idx;
   logic [LW-1:0] b_idx;

   logic in_xfer;
   logic out_xfer;
   logic load_last;
   logic issue_last;
   logic drain_last;
   logic row_last;

   // The MAC's valid_out is not needed because sampling happens at a fixed latency.
   logic unused_mac_valid_out;
   assign unused_mac_valid_out = mac_valid_out;

   assign in_xfer    = input_valid && input_ready;
   assign out_xfer   = output_valid && output_ready;
   assign load_last  = (load_cnt == LW'(TOTAL - 1));
   assign issue_last = (step == SW'(N - 1));
   assign drain_last = (step == SW'(MAC_LAT - 1));
   assign row_last   = (row == RW'(M - 1));
   assign a_idx      = LW'(int'(row) * N + int'(step));
   assign b_idx      = LW'(M * N + int'(step));

   // State register; any reset abandons the current job and returns to loading.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOAD;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode: load all words, then CLR/ISSUE/DRAIN/OUT once per row.
   always_comb begin
      state_next = state;
      case (state)
         LOAD:    if (in_xfer && load_last) state_next = CLR;
         CLR:     state_next = ISSUE;
         ISSUE:   if (issue_last) state_next = DRAIN;
         DRAIN:   if (drain_last) state_next = OUT;
         OUT:     if (out_xfer) state_next = row_last ? LOAD : CLR;
         default: state_next = LOAD;
      endcase
   end

   // Output decode from the registered state; the MAC port idles at zero outside ISSUE.
   always_comb begin
      input_ready  = 1'b0;
      mac_a        = '0;
      mac_b        = '0;
      mac_valid_in = 1'b0;
      mac_clr      = 1'b0;
      output_valid = 1'b0;
      case (state)
         LOAD:  input_ready = !reset;
         CLR:   mac_clr = 1'b1;
         ISSUE: begin
            mac_a        = words[a_idx];
            mac_b        = words[b_idx];
            mac_valid_in = 1'b1;
         end
         OUT:   output_valid = 1'b1;
         default: ;
      endcase
   end

   // Load, row and step counters; step counts issue beats, then drain cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_cnt <= '0;
         row      <= '0;
         step     <= '0;
      end else begin
         if (in_xfer) begin
            load_cnt <= load_last ? '0 : load_cnt + 1'b1;
         end
         case (state)
            LOAD:    row <= '0;
            OUT:     if (out_xfer && !row_last) row <= row + 1'b1;
            default: ;
         endcase
         case (state)
            ISSUE:   step <= issue_last ? '0 : step + 1'b1;
            DRAIN:   step <= drain_last ? '0 : step + 1'b1;
            default: step <= '0;
         endcase
      end
   end

   // Operand storage; stale contents are harmless because a job always reloads every slot.
   always_ff @(posedge clk) begin
      if (in_xfer) begin
         words[load_cnt] <= input_data;
      end
   end

   // Capture the finished row sum on the final drain cycle and hold it until consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         output_data <= '0;
      end else if (state == DRAIN && drain_last) begin
         output_data <= mac_f;
      end
   end

endmodule

// File: tb/tb_mvm_sequencer.sv
// tb_mvm_sequencer: directed bench for mvm_sequencer with a behavioural
// saturating MAC attached and a queue of expected row results.
module tb_mvm_sequencer;

   localparam int M       = 3;
   localparam int N       = 3;
   localparam int W       = 10;
   localparam int ACCW    = 20;
   localparam int MAC_LAT = 3;
   localparam int TOTAL   = M * N + N;
   localparam longint MAXV = (64'sd1 <<< (ACCW - 1)) - 1;
   localparam longint MINV = -(64'sd1 <<< (ACCW - 1));

   logic            clk;
   logic            reset;
   logic [W-1:0]    input_data;
   logic            input_valid;
   logic            input_ready;
   logic [W-1:0]    mac_a;
   logic [W-1:0]    mac_b;
   logic            mac_valid_in;
   logic            mac_clr;
   logic [ACCW-1:0] mac_f;
   logic            mac_valid_out;
   logic [ACCW-1:0] output_data;
   logic            output_valid;
   logic            output_ready;

   int n_compared   = 0;
   int n_mismatched = 0;
   int cycle        = 0;
   int accepted     = 0;
   int load_done_cycle = 0;
   int sb[$];
   int job_a[M*N];
   int job_x[N];

   mvm_sequencer #(
      .M(M), .N(N), .W(W), .ACCW(ACCW), .MAC_LAT(MAC_LAT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .input_data(input_data),
      .input_valid(input_valid),
      .input_ready(input_ready),
      .mac_a(mac_a),
      .mac_b(mac_b),
      .mac_valid_in(mac_valid_in),
      .mac_clr(mac_clr),
      .mac_f(mac_f),
      .mac_valid_out(mac_valid_out),
      .output_data(output_data),
      .output_valid(output_valid),
      .output_ready(output_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle and accepted-word counters used for latency and backpressure checks.
   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (input_valid && input_ready) accepted <= accepted + 1;
   end

   // Behavioural MAC: operand register, product register, saturating accumulator.
   logic signed [W-1:0]    s1_a, s1_b;
   logic                   s1_v;
   logic signed [2*W-1:0]  s2_p;
   logic                   s2_v;
   logic signed [ACCW-1:0] acc_q;
   logic                   mv_q;

   function automatic logic signed [ACCW-1:0] sat_add(input logic signed [ACCW-1:0] a,
                                                      input logic signed [2*W-1:0] p);
      longint s;
      s = longint'(a) + longint'(p);
      if (s > MAXV) s = MAXV;
      if (s < MINV) s = MINV;
      return ACCW'(s);
   endfunction

   // MAC pipeline; reset | mac_clr clears every stage.
   always @(posedge clk) begin
      if (reset || mac_clr) begin
         s1_a  <= '0;
         s1_b  <= '0;
         s1_v  <= 1'b0;
         s2_p  <= '0;
         s2_v  <= 1'b0;
         acc_q <= '0;
         mv_q  <= 1'b0;
      end else begin
         s1_a <= $signed(mac_a);
         s1_b <= $signed(mac_b);
         s1_v <= mac_valid_in;
         s2_p <= s1_a * s1_b;
         s2_v <= s1_v;
         if (s2_v) acc_q <= sat_add(acc_q, s2_p);
         mv_q <= s2_v;
      end
   end

   assign mac_f         = acc_q;
   assign mac_valid_out = mv_q;

   // Reference dot product with per-step saturation for row r of the current job.
   function automatic int row_dot(input int r);
      longint acc;
      acc = 0;
      for (int k = 0; k < N; k++) begin
         acc = acc + longint'(job_a[r*N + k]) * longint'(job_x[k]);
         if (acc > MAXV) acc = MAXV;
         if (acc < MINV) acc = MINV;
      end
      return int'(acc);
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic push_expected();
      for (int r = 0; r < M; r++) sb.push_back(row_dot(r));
   endtask

   // Drive job words from index 'start'; 'gap' inserts an idle cycle after each word.
   task automatic apply_stimulus(input bit gap, input int start);
      for (int i = start; i < TOTAL; i++) begin
         if (i < M*N) input_data = W'(job_a[i]);
         else         input_data = W'(job_x[i - M*N]);
         input_valid = 1'b1;
         @(negedge clk);
         if (gap && i < TOTAL - 1) begin
            input_valid = 1'b0;
            @(negedge clk);
         end
      end
      input_valid = 1'b0;
      load_done_cycle = cycle;
   endtask

   task automatic wait_output();
      int waited;
      waited = 0;
      while (output_valid !== 1'b1 && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      check_output("out_valid_seen", 32'(output_valid), 32'd1);
   endtask

   // Pop and compare n results; the handshake completes on the following posedge.
   task automatic drain_outputs(input int n, input bit chk_first, input bit chk_period);
      int prev;
      int exp_y;
      int obs_y;
      prev = 0;
      for (int i = 0; i < n; i++) begin
         wait_output();
         obs_y = int'($signed(output_data));
         exp_y = (sb.size() > 0) ? sb.pop_front() : 32'h0DEAD_BEE;
         check_output("y_row", obs_y, exp_y);
         if (chk_first && i == 0) check_output("first_latency", cycle - load_done_cycle, 7);
         if (chk_period && i > 0) check_output("row_period", cycle - prev, 8);
         prev = cycle;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [W-1:0] exp_w;
      int base;
      int exp_y;

      reset        = 1'b1;
      input_data   = '0;
      input_valid  = 1'b0;
      output_ready = 1'b1;

      // Reset behaviour.
      @(negedge clk);
      check_output("ready_in_reset", 32'(input_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_output("rst_input_ready", 32'(input_ready), 32'd1);
      check_output("rst_output_valid", 32'(output_valid), 32'd0);
      check_output("rst_output_data", 32'(output_data), 32'd0);
      check_output("rst_mac_valid_in", 32'(mac_valid_in), 32'd0);
      check_output("rst_mac_clr", 32'(mac_clr), 32'd0);
      check_output("rst_mac_a", 32'(mac_a), 32'd0);
      check_output("rst_mac_b", 32'(mac_b), 32'd0);
      @(negedge clk);

      // Identity matrix: latency, CLR/ISSUE decode and row period.
      $display("[TB] identity job");
      job_a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
      job_x = '{5, -3, 7};
      apply_stimulus(1'b0, 0);
      push_expected();
      check_output("clr_mac_clr", 32'(mac_clr), 32'd1);
      check_output("clr_valid_in", 32'(mac_valid_in), 32'd0);
      check_output("clr_input_ready", 32'(input_ready), 32'd0);
      @(negedge clk);
      check_output("issue_valid_in", 32'(mac_valid_in), 32'd1);
      check_output("issue_mac_clr", 32'(mac_clr), 32'd0);
      exp_w = W'(job_a[0]);
      check_output("issue_mac_a", 32'(mac_a), 32'(exp_w));
      exp_w = W'(job_x[0]);
      check_output("issue_mac_b", 32'(mac_b), 32'(exp_w));
      drain_outputs(M, 1'b1, 1'b1);

      // Mixed-sign matrix.
      $display("[TB] mixed job");
      job_a = '{1, 2, 3, 4, 5, 6, -1, -1, -1};
      job_x = '{1, 1, 1};
      apply_stimulus(1'b0, 0);
      push_expected();
      drain_outputs(M, 1'b0, 1'b1);

      // Positive and negative saturation.
      $display("[TB] saturation jobs");
      job_a = '{511, 511, 511, 511, 511, 511, 511, 511, 511};
      job_x = '{511, 511, 511};
      apply_stimulus(1'b0, 0);
      push_expected();
      drain_outputs(M, 1'b0, 1'b1);
      job_a = '{-512, -512, -512, -512, -512, -512, -512, -512, -512};
      job_x = '{511, 511, 511};
      apply_stimulus(1'b0, 0);
      push_expected();
      drain_outputs(M, 1'b0, 1'b1);

      // Backpressure: hold output_ready low for 10 cycles with a word on offer.
      $display("[TB] backpressure job");
      output_ready = 1'b0;
      job_a = '{3, 1, -2, 0, 4, 5, 7, -7, 1};
      job_x = '{2, -1, 3};
      apply_stimulus(1'b0, 0);
      push_expected();
      wait_output();
      exp_y = sb[0];
      base = accepted;
      input_data  = 10'd77;
      input_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_output("bp_valid", 32'(output_valid), 32'd1);
         check_output("bp_data", int'($signed(output_data)), exp_y);
         check_output("bp_mac_valid_in", 32'(mac_valid_in), 32'd0);
         check_output("bp_input_ready", 32'(input_ready), 32'd0);
      end
      input_valid = 1'b0;
      check_output("bp_no_accept", accepted - base, 0);
      check_output("bp_y_row", int'($signed(output_data)), sb.pop_front());
      output_ready = 1'b1;
      @(negedge clk);
      drain_outputs(M - 1, 1'b0, 1'b0);

      // Input bubbles; a 13th word stays pending until the last output drains.
      $display("[TB] bubble job");
      job_a = '{1, 2, 3, 4, 5, 6, -1, -1, -1};
      job_x = '{1, 1, 1};
      base = accepted;
      apply_stimulus(1'b1, 0);
      check_output("bubble_accepted", accepted - base, TOTAL);
      push_expected();
      job_a = '{300, 300, 300, 300, 300, 300, 300, 300, 300};
      job_x = '{-400, 250, -100};
      input_data  = W'(job_a[0]);
      input_valid = 1'b1;
      drain_outputs(M, 1'b0, 1'b1);
      check_output("word13_held", accepted - base, TOTAL);
      @(negedge clk);
      check_output("word13_taken", accepted - base, TOTAL + 1);

      // Abort a job with reset during ISSUE of row 1.
      $display("[TB] reset during job");
      apply_stimulus(1'b0, 1);
      push_expected();
      drain_outputs(1, 1'b0, 1'b0);
      check_output("row1_clr", 32'(mac_clr), 32'd1);
      @(negedge clk);
      check_output("row1_issue_valid", 32'(mac_valid_in), 32'd1);
      exp_w = W'(job_a[N]);
      check_output("row1_issue_a", 32'(mac_a), 32'(exp_w));
      reset = 1'b1;
      #1;
      check_output("abort_ready_in_reset", 32'(input_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_output("abort_output_valid", 32'(output_valid), 32'd0);
      check_output("abort_input_ready", 32'(input_ready), 32'd1);
      check_output("abort_mac_valid_in", 32'(mac_valid_in), 32'd0);
      sb.delete();
      @(negedge clk);
      job_a = '{1, 2, 3, 4, 5, 6, -1, -1, -1};
      job_x = '{1, 1, 1};
      apply_stimulus(1'b0, 0);
      push_expected();
      drain_outputs(M, 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/mvm_sequencer.md
# mvm_sequencer

Control and storage stage that wraps the saturating MAC unit to perform an M×N signed matrix–vector multiply. It accepts a matrix and a vector over a valid/ready input stream and stores them locally. For each matrix row it clears the MAC and issues N operand pairs on the MAC's a/b/valid_in port. It then captures the saturated dot product from the MAC's f output and presents it on a valid/ready output stream.

## Interface
- M, 3, matrix rows (number of results per job)
- N, 3, matrix columns / vector length (products per row)
- W, 10, signed operand width (matches MAC a/b)
- ACCW, 20, signed accumulator width (matches MAC f)
- MAC_LAT, 3, cycles from the last mac_valid_in beat until mac_f holds the complete row sum

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- input_data  in  W  signed operand word
- input_valid  in  1  input_data valid this cycle
- input_ready  out  1  block accepts input_data this cycle
- mac_a  out  W  MAC operand a
- mac_b  out  W  MAC operand b
- mac_valid_in  out  1  MAC valid_in
- mac_clr  out  1  accumulator clear; top level drives the MAC reset as reset | mac_clr
- mac_f  in  ACCW  MAC accumulated result
- mac_valid_out  in  1  MAC valid_out; unused, sampling is fixed-latency
- output_data  out  ACCW  row result y[r]
- output_valid  out  1  output_data valid
- output_ready  in  1  downstream accepts output_data

## Operation
- Storage: M*N matrix registers and N vector registers, each W bits.
- Input order: M*N matrix words in row-major order (A[0][0], A[0][1], …), then N vector words x[0..N-1].
- A word transfers when input_valid && input_ready.
- FSM states and transitions:
  - LOAD: input_ready=1. A load counter advances on each transfer. After the (M*N+N)-th transfer, go to CLR with row=0.
  - CLR: one cycle. mac_clr=1, mac_valid_in=0. Go to ISSUE with k=0.
  - ISSUE: N cycles. mac_a=A[row][k], mac_b=x[k], mac_valid_in=1. k increments each cycle. At k=N-1, go to DRAIN.
  - DRAIN: MAC_LAT cycles, mac_valid_in=0. On the last DRAIN cycle, output_data<=mac_f and output_valid<=1. Go to OUT.
  - OUT: hold output_data until output_valid && output_ready. On the handshake, clear output_valid. If row<M-1, increment row and go to CLR; otherwise go to LOAD.
- Outside ISSUE: mac_a=0, mac_b=0, mac_valid_in=0. mac_clr=1 only in CLR.
- input_ready=0 in every state except LOAD; no input words are accepted while a job is running.
- Arithmetic is owned by the MAC: products are W×W signed and accumulation saturates to [-2^(ACCW-1), 2^(ACCW-1)-1]. This block passes mac_f through unmodified.
- Input gaps (input_valid=0) in LOAD stall the load counter only.
- Reset in any state: FSM returns to LOAD, all counters clear, and stored data is discarded (the register contents need not be cleared).

## Timing
- Reset values: input_ready=1 from the first cycle after reset deasserts (0 while reset is high). output_valid=0, output_data=0, mac_valid_in=0, mac_clr=0, mac_a=0, mac_b=0.
- FSM outputs decode combinationally from registered state and counters.
- Per-row latency from entering CLR to output_valid rising is 1 + N + MAC_LAT cycles. With defaults this is 7.
- First output_valid appears 7 cycles after the last input word transfers (defaults).
- An output stays valid until consumed; backpressure on output_ready stalls the whole pipeline in OUT.
- The minimum row period is 8 cycles (7, plus 1 for the OUT handshake when output_ready=1).
- A handshake at the last row in OUT and input_valid=1 on the same cycle: the word is not accepted. LOAD begins next cycle.

## Test plan
- Identity A=I (3×3), x=[5,-3,7], output_ready=1 -> outputs 5, -3, 7 in order. Each output arrives 8 cycles after the previous one.
- A=[[1,2,3],[4,5,6],[-1,-1,-1]], x=[1,1,1] -> outputs 6, 15, -3.
- Positive saturation: all A and x = 511 -> each row 783363 clamps to 524287. Negative saturation: A=-512, x=511 -> -524288.
- Backpressure: output_ready low for 10 cycles while output_valid=1 -> output_data stable, mac_valid_in=0, input_ready=0. Release -> next row proceeds.
- Input bubbles: input_valid toggles 1,0,1,0 across all 12 words -> results identical to the gap-free case. Exactly 12 words accepted; the 13th offered word is not accepted until all 3 outputs drain.
- Reset asserted for one cycle during ISSUE of row 1 -> output_valid=0 and input_ready=1 after reset. A fresh 12-word job then yields correct results with no residue from the aborted job.
